// File: rtl/seq_signed_divider.sv
// Multicycle signed divider (restoring shift-subtract, one quotient bit per cycle).
// It follows MIPS DIV rules: the quotient truncates toward zero and the remainder keeps the dividend's sign.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; a zero divisor gives a dzero pulse
// RUN   | WIDTH shift/trial-subtract iterations on the operand magnitudes
// FIX   | apply the signs to the results, pulse done, return to IDLE
module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             dzero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] rem_q, rem_nx;
    logic [WIDTH-1:0] dvd_q, dvd_nx;
    logic [WIDTH-1:0] dvs_q, dvs_nx;
    logic [WIDTH-1:0] quo_nx, rmd_nx;
    logic [CW-1:0]    count_q, count_nx;
    logic             sgn_quo, sgn_quo_nx;
    logic             sgn_rem, sgn_rem_nx;
    logic             done_nx, dzero_nx;
    logic [WIDTH:0]   shifted, trial;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            count_q   <= '0;
            sgn_quo   <= 1'b0;
            sgn_rem   <= 1'b0;
            done      <= 1'b0;
            dzero     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state     <= state_nx;
            rem_q     <= rem_nx;
            dvd_q     <= dvd_nx;
            dvs_q     <= dvs_nx;
            count_q   <= count_nx;
            sgn_quo   <= sgn_quo_nx;
            sgn_rem   <= sgn_rem_nx;
            done      <= done_nx;
            dzero     <= dzero_nx;
            quotient  <= quo_nx;
            remainder <= rmd_nx;
        end
    end

    // The dividend register doubles as the quotient shift register: the quotient bits shift into its LSB.
    always_comb begin
        state_nx   = state;
        rem_nx     = rem_q;
        dvd_nx     = dvd_q;
        dvs_nx     = dvs_q;
        count_nx   = count_q;
        sgn_quo_nx = sgn_quo;
        sgn_rem_nx = sgn_rem;
        quo_nx     = quotient;
        rmd_nx     = remainder;
        done_nx    = 1'b0;
        dzero_nx   = 1'b0;
        shifted    = {rem_q, dvd_q[WIDTH-1]};
        trial      = shifted - {1'b0, dvs_q};

        case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // A held start must still give dzero as a single-cycle pulse.
                        dzero_nx = !dzero;
                    end else begin
                        sgn_quo_nx = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sgn_rem_nx = dividend[WIDTH-1];
                        dvd_nx     = dividend[WIDTH-1] ? -dividend : dividend;
                        dvs_nx     = divisor[WIDTH-1]  ? -divisor  : divisor;
                        rem_nx     = '0;
                        count_nx   = '0;
                        state_nx   = RUN;
                    end
                end
            end
            RUN: begin
                dvd_nx   = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_nx   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                count_nx = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                quo_nx   = sgn_quo ? -dvd_q : dvd_q;
                rmd_nx   = sgn_rem ? -rem_q : rem_q;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Multicycle signed 32-bit divider that sits beside the control unit and the Hi/Lo source muxes.
- It is the responder side of the DIV_on handshake: the control unit pulses start with operands from A/B, waits for done or dzero, then loads remainder into Hi and quotient into Lo.
- It uses a restoring shift-subtract algorithm, one quotient bit per cycle, with MIPS DIV semantics.

Parameters:
WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
dividend  input  WIDTH  signed dividend (A), sampled on the start edge
divisor  input  WIDTH  signed divisor (B), sampled on the start edge
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; quotient/remainder are valid and new
dzero  output  1  one-cycle pulse; divide-by-zero detected, no result produced
quotient  output  WIDTH  signed quotient, to the Lo mux
remainder  output  WIDTH  signed remainder, to the Hi mux

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - busy, done, dzero, quotient, remainder all 0.
  - Internal registers cleared.
  - Reset asserted mid-operation aborts the division: no done, and outputs return to 0.
- States: IDLE, RUN, FIX.
- IDLE, on a rising edge (E0) with start=1:
  - If divisor==0: dzero=1 for the following cycle, stay in IDLE, busy stays 0, quotient/remainder unchanged.
  - Else:
    - Latch sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
    - Load the magnitudes |dividend| and |divisor| as unsigned WIDTH-bit values; |-2^(W-1)| = 2^(W-1).
    - Clear the partial remainder, count=0, busy=1, go to RUN.
- RUN, one iteration per edge (E1..E_WIDTH):
  - Shift {partial_rem, dividend_mag} left by 1.
  - trial = partial_rem - divisor_mag, computed WIDTH+1 bits wide.
  - If trial is non-negative: partial_rem = trial and quotient bit = 1; else restore and quotient bit = 0.
  - count increments; after the WIDTH-th iteration go to FIX.
- FIX, edge E_(WIDTH+1):
  - quotient = sign_q ? -q_mag : q_mag.
  - remainder = sign_r ? -r_mag : r_mag.
  - done=1 for exactly one cycle, busy=0 on the same edge, go to IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH+1 (33 edges for WIDTH=32). busy is high for exactly WIDTH+1 cycles.
- Semantics:
  - Quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Invariant: dividend == quotient*divisor + remainder, with |remainder| < |divisor|.
- Overflow case -2^31 / -1: quotient=0x80000000, remainder=0. This is the natural result of the algorithm; no flag is raised.
- start while busy=1 is ignored: no restart and no queuing. Operands may change freely after E0.
- start in the same cycle that done is high (state IDLE) is accepted normally.
- quotient/remainder hold their last values until the next FIX edge. A dzero event does not modify them.
- done and dzero are never high simultaneously. Both are single-cycle pulses, even if start is held high.
- A held-high start in IDLE starts a new division every time the block returns to IDLE. The control unit is required to pulse start.

Test Plan:
- 7 / 2 -> after 33 edges done=1 for one cycle; quotient=3, remainder=1; busy high for exactly 33 cycles.
- -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- 7 / -2 -> quotient=-3, remainder=1. Also 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- 100 / 0 -> dzero=1 in the cycle after start, busy never rises, done never rises, quotient/remainder keep the prior values (3/1).
- Start 1000 / 7; pulse start with 9 / 3 at cycle 10 -> second start ignored; done at cycle 33 with quotient=142, remainder=6.
- Start 1000 / 7; assert reset at cycle 15 asynchronously, between edges -> all outputs 0 immediately. After release, 15 / 4 completes with quotient=3, remainder=3.
- Randomized signed operands (500 pairs, nonzero divisor) -> the invariant holds and the results match the reference-model truncating division.
